// File: rtl/uart_frame_rx.sv
// UART packet receiver: STX, fixed-length payload, ETX.
// Mid-bit sampling, optional parity, watchdog, one-entry output buffer.
module uart_frame_rx #(
  parameter int         CLKS_PER_BIT  = 2604,
  parameter int         PAYLOAD_BYTES = 6,
  parameter logic [7:0] STX_BYTE      = 8'h02,
  parameter logic [7:0] ETX_BYTE      = 8'h03,
  parameter bit         PARITY_EN     = 1'b0,
  parameter bit         PARITY_ODD    = 1'b0,
  parameter int         TIMEOUT_CLKS  = 500000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rxd,
  output logic [8*PAYLOAD_BYTES-1:0] pkt_data,
  output logic                       pkt_valid,
  input  logic                       pkt_ready,
  output logic                       frame_err,
  output logic                       parity_err,
  output logic                       timeout_err,
  output logic                       overrun_err,
  output logic                       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int IW = $clog2(PAYLOAD_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(PAYLOAD_BYTES - 1);
  localparam logic [TW-1:0] TO_M1    = TW'(TIMEOUT_CLKS - 1);

  localparam logic [2:0] B_IDLE  = 3'd0;
  localparam logic [2:0] B_START = 3'd1;
  localparam logic [2:0] B_DATA  = 3'd2;
  localparam logic [2:0] B_PAR   = 3'd3;
  localparam logic [2:0] B_STOP  = 3'd4;
  localparam logic [2:0] B_WAIT  = 3'd5;

  localparam logic [1:0] P_STX  = 2'd0;
  localparam logic [1:0] P_DATA = 2'd1;
  localparam logic [1:0] P_ETX  = 2'd2;

  logic                       s1, s2, s3;
  logic [2:0]                 bstate;
  logic [CW-1:0]              cnt;
  logic [3:0]                 bcnt;
  logic [7:0]                 shreg;
  logic                       byte_done;
  logic                       byte_ferr;
  logic                       byte_perr;

  logic [1:0]                 pstate;
  logic [IW-1:0]              idx;
  logic [8*PAYLOAD_BYTES-1:0] stage;
  logic [TW-1:0]              wd;
  logic                       p_ferr;

  assign frame_err  = byte_ferr | p_ferr;
  assign parity_err = byte_perr;

  // s3 is the previous synchronised sample, used for start-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= 1'b1;
      s2        <= 1'b1;
      s3        <= 1'b1;
      bstate    <= B_IDLE;
      cnt       <= '0;
      bcnt      <= '0;
      shreg     <= '0;
      byte_done <= 1'b0;
      byte_ferr <= 1'b0;
      byte_perr <= 1'b0;
    end else begin
      s1        <= rxd;
      s2        <= s1;
      s3        <= s2;
      byte_done <= 1'b0;
      byte_ferr <= 1'b0;
      byte_perr <= 1'b0;
      case (bstate)
        B_IDLE: begin
          if (s3 && !s2) begin
            bstate <= B_START;
            cnt    <= '0;
          end
        end
        B_START: begin
          if (cnt == HALF_M1) begin
            cnt    <= '0;
            bcnt   <= '0;
            bstate <= s2 ? B_IDLE : B_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        B_DATA: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            shreg <= {s2, shreg[7:1]};
            bcnt  <= bcnt + 1'b1;
            if (bcnt == 4'd7)
              bstate <= PARITY_EN ? B_PAR : B_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        B_PAR: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if ((^shreg ^ s2) != PARITY_ODD) begin
              byte_perr <= 1'b1;
              bstate    <= B_IDLE;
            end else begin
              bstate <= B_STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        B_STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (s2) begin
              byte_done <= 1'b1;
              bstate    <= B_IDLE;
            end else begin
              byte_ferr <= 1'b1;
              bstate    <= B_WAIT;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        B_WAIT: begin
          if (s2)
            bstate <= B_IDLE;
        end
        default: bstate <= B_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pstate      <= P_STX;
      idx         <= '0;
      stage       <= '0;
      wd          <= '0;
      busy        <= 1'b0;
      pkt_data    <= '0;
      pkt_valid   <= 1'b0;
      p_ferr      <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      p_ferr      <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
      if (pkt_valid && pkt_ready)
        pkt_valid <= 1'b0;
      if (byte_done || !busy)
        wd <= '0;
      else
        wd <= wd + 1'b1;
      if (byte_ferr || byte_perr) begin
        pstate <= P_STX;
        busy   <= 1'b0;
      end else if (busy && !byte_done && wd == TO_M1) begin
        timeout_err <= 1'b1;
        pstate      <= P_STX;
        busy        <= 1'b0;
      end else if (byte_done) begin
        case (pstate)
          P_STX: begin
            if (shreg == STX_BYTE) begin
              pstate <= P_DATA;
              idx    <= '0;
              busy   <= 1'b1;
            end
          end
          P_DATA: begin
            stage[{idx, 3'b000} +: 8] <= shreg;
            if (idx == LAST_IDX)
              pstate <= P_ETX;
            else
              idx <= idx + 1'b1;
          end
          P_ETX: begin
            pstate <= P_STX;
            busy   <= 1'b0;
            if (shreg != ETX_BYTE) begin
              p_ferr <= 1'b1;
            end else if (!pkt_valid || pkt_ready) begin
              // a same-cycle handshake frees the slot for the new packet
              pkt_data  <= stage;
              pkt_valid <= 1'b1;
            end else begin
              overrun_err <= 1'b1;
            end
          end
          default: pstate <= P_STX;
        endcase
      end
    end
  end

endmodule
